// File: rtl/carrier_counter_if.sv
// Control/status bundle for the multi-channel carrier counter.
// The master side drives configuration and sync; the slave side returns counts and event pulses.
interface carrier_counter_if #(
    parameter int WIDTH  = 8,
    parameter int NUM_CH = 3
);
    logic                    enable;
    logic [1:0]              mode;
    logic [WIDTH-1:0]        max_count;
    logic                    sync_load;
    logic [NUM_CH*WIDTH-1:0] phase;
    logic [NUM_CH-1:0]       phase_dir;
    logic [NUM_CH*WIDTH-1:0] count;
    logic [NUM_CH-1:0]       dir;
    logic [NUM_CH-1:0]       zero_pulse;
    logic [NUM_CH-1:0]       top_pulse;
    logic [WIDTH-1:0]        max_act;

    modport master (
        output enable, mode, max_count, sync_load, phase, phase_dir,
        input  count, dir, zero_pulse, top_pulse, max_act
    );

    modport slave (
        input  enable, mode, max_count, sync_load, phase, phase_dir,
        output count, dir, zero_pulse, top_pulse, max_act
    );
endinterface

// File: rtl/carrier_counter.sv
// Multi-channel phase-shiftable carrier counter with a shadowed period register.
// mode | meaning: 00 up-wrap | 01 down-wrap | 10 up-down triangle | 11 hold
module carrier_counter #(
    parameter int WIDTH  = 8,
    parameter int NUM_CH = 3
) (
    input logic              clk,
    input logic              reset_n,
    carrier_counter_if.slave bus
);
    typedef enum logic [1:0] {
        M_UP   = 2'b00,
        M_DOWN = 2'b01,
        M_UPDN = 2'b10,
        M_HOLD = 2'b11
    } mode_e;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [NUM_CH-1:0][WIDTH-1:0] count_q, count_d;
    logic [NUM_CH-1:0]            dir_q, dir_d;
    logic [NUM_CH-1:0]            zp_q, zp_d;
    logic [NUM_CH-1:0]            tp_q, tp_d;
    logic [WIDTH-1:0]             max_q, max_d;

    mode_e            mode;
    logic             step_en;
    logic             bnd0;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] nxt;
    logic [WIDTH-1:0] ph;

    assign mode    = mode_e'(bus.mode);
    assign step_en = bus.enable && (mode != M_HOLD);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
            dir_q   <= '1;
            zp_q    <= '0;
            tp_q    <= '0;
            max_q   <= '1;
        end else begin
            count_q <= count_d;
            dir_q   <= dir_d;
            zp_q    <= zp_d;
            tp_q    <= tp_d;
            max_q   <= max_d;
        end
    end

    always_comb begin
        count_d = count_q;
        dir_d   = dir_q;
        zp_d    = '0;
        tp_d    = '0;
        max_d   = max_q;
        bnd0    = 1'b0;
        cnt     = '0;
        nxt     = '0;
        ph      = '0;

        if (bus.sync_load) begin
            for (int i = 0; i < NUM_CH; i++) begin
                ph          = bus.phase[i*WIDTH +: WIDTH];
                count_d[i]  = (ph > max_q) ? max_q : ph;
            end
            dir_d = bus.phase_dir;
        end else begin
            if (step_en) begin
                for (int i = 0; i < NUM_CH; i++) begin
                    cnt = count_q[i];
                    nxt = cnt;
                    // A zero period pins every channel at 0 regardless of mode.
                    if (max_q == '0) begin
                        count_d[i] = '0;
                        zp_d[i]    = 1'b1;
                    end else begin
                        case (mode)
                            M_UP: begin
                                if (cnt >= max_q) begin
                                    count_d[i] = '0;
                                    zp_d[i]    = 1'b1;
                                end else begin
                                    nxt        = cnt + ONE;
                                    count_d[i] = nxt;
                                    tp_d[i]    = (nxt == max_q);
                                end
                            end
                            M_DOWN: begin
                                if (cnt == '0) begin
                                    count_d[i] = max_q;
                                    tp_d[i]    = 1'b1;
                                end else begin
                                    nxt        = cnt - ONE;
                                    count_d[i] = nxt;
                                    zp_d[i]    = (nxt == '0);
                                end
                            end
                            M_UPDN: begin
                                if (dir_q[i]) begin
                                    if (cnt >= max_q) begin
                                        nxt      = max_q - ONE;
                                        dir_d[i] = 1'b0;
                                        zp_d[i]  = (nxt == '0);
                                    end else begin
                                        nxt     = cnt + ONE;
                                        tp_d[i] = (nxt == max_q);
                                    end
                                end else begin
                                    if (cnt == '0) begin
                                        nxt      = ONE;
                                        dir_d[i] = 1'b1;
                                        tp_d[i]  = (max_q == ONE);
                                    end else begin
                                        nxt     = cnt - ONE;
                                        zp_d[i] = (nxt == '0);
                                    end
                                end
                                count_d[i] = nxt;
                            end
                            default: ;
                        endcase
                    end
                end

                case (mode)
                    M_UP:    bnd0 = (count_q[0] >= max_q);
                    M_DOWN:  bnd0 = (count_q[0] == '0);
                    M_UPDN:  bnd0 = (count_q[0] == '0) && (!dir_q[0] || (max_q == '0));
                    default: bnd0 = 1'b0;
                endcase
            end

            if (!step_en || bnd0) begin
                max_d = bus.max_count;
            end
        end
    end

    assign bus.count      = count_q;
    assign bus.dir        = dir_q;
    assign bus.zero_pulse = zp_q;
    assign bus.top_pulse  = tp_q;
    assign bus.max_act    = max_q;
endmodule

// File: tb/tb_carrier_counter.sv
// Directed-vector bench for carrier_counter (WIDTH=8, NUM_CH=3).
module tb_carrier_counter;
    localparam logic [1:0] UP = 2'b00, DN = 2'b01, UD = 2'b10, HD = 2'b11;

    typedef struct {
        logic        en;
        logic [1:0]  mode;
        logic [7:0]  maxc;
        logic        sl;
        logic [23:0] ph;
        logic [2:0]  pdir;
        logic [23:0] ecnt;
        logic [2:0]  edir;
        logic [2:0]  ezp;
        logic [2:0]  etp;
        logic [7:0]  emax;
    } vec_t;

    logic clk;
    logic reset_n;
    int   total;
    int   bad;
    vec_t vecs[$];

    carrier_counter_if #(.WIDTH(8), .NUM_CH(3)) bus ();

    carrier_counter #(.WIDTH(8), .NUM_CH(3)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [23:0] a3(input logic [7:0] x);
        return {x, x, x};
    endfunction

    function automatic logic [23:0] c3(input logic [7:0] c2, input logic [7:0] c1, input logic [7:0] c0);
        return {c2, c1, c0};
    endfunction

    task automatic add(input logic en, input logic [1:0] mode, input logic [7:0] maxc, input logic sl,
                       input logic [23:0] ph, input logic [2:0] pdir, input logic [23:0] ecnt,
                       input logic [2:0] edir, input logic [2:0] ezp, input logic [2:0] etp,
                       input logic [7:0] emax);
        vec_t v;
        v.en = en; v.mode = mode; v.maxc = maxc; v.sl = sl; v.ph = ph; v.pdir = pdir;
        v.ecnt = ecnt; v.edir = edir; v.ezp = ezp; v.etp = etp; v.emax = emax;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s step %0d: got %0h want %0h", name, idx, act, exp);
        end
    endtask

    task automatic chk_all(input int idx, input logic [23:0] ecnt, input logic [2:0] edir,
                           input logic [2:0] ezp, input logic [2:0] etp, input logic [7:0] emax);
        chk("count", idx, 32'(bus.count), 32'(ecnt));
        chk("dir", idx, 32'(bus.dir), 32'(edir));
        chk("zero_pulse", idx, 32'(bus.zero_pulse), 32'(ezp));
        chk("top_pulse", idx, 32'(bus.top_pulse), 32'(etp));
        chk("max_act", idx, 32'(bus.max_act), 32'(emax));
    endtask

    task automatic drive(input logic en, input logic [1:0] mode, input logic [7:0] maxc,
                         input logic sl, input logic [23:0] ph, input logic [2:0] pdir);
        bus.enable = en; bus.mode = mode; bus.max_count = maxc;
        bus.sync_load = sl; bus.phase = ph; bus.phase_dir = pdir;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;

        // up mode, period 5 (max_act loaded while disabled)
        add(0, UP, 4, 0, 0, 7, a3(0), 7, 0, 0, 4);
        for (int k = 1; k <= 3; k++) add(1, UP, 4, 0, 0, 7, a3(8'(k)), 7, 0, 0, 4);
        add(1, UP, 4, 0, 0, 7, a3(4), 7, 0, 7, 4);
        add(1, UP, 4, 0, 0, 7, a3(0), 7, 7, 0, 4);
        add(1, UP, 4, 0, 0, 7, a3(1), 7, 0, 0, 4);
        // up-down, max 3; sync_load leaves max_act alone
        add(1, UD, 3, 1, 0, 7, a3(0), 7, 0, 0, 4);
        add(0, UD, 3, 0, 0, 7, a3(0), 7, 0, 0, 3);
        add(1, UD, 3, 0, 0, 7, a3(1), 7, 0, 0, 3);
        add(1, UD, 3, 0, 0, 7, a3(2), 7, 0, 0, 3);
        add(1, UD, 3, 0, 0, 7, a3(3), 7, 0, 7, 3);
        add(1, UD, 3, 0, 0, 7, a3(2), 0, 0, 0, 3);
        add(1, UD, 3, 0, 0, 7, a3(1), 0, 0, 0, 3);
        add(1, UD, 3, 0, 0, 7, a3(0), 0, 7, 0, 3);
        add(1, UD, 3, 0, 0, 7, a3(1), 7, 0, 0, 3);
        // phase shift {2,1,0}
        add(1, UD, 3, 1, c3(2, 1, 0), 7, c3(2, 1, 0), 7, 0, 0, 3);
        add(1, UD, 3, 0, 0, 7, c3(3, 2, 1), 7, 0, 4, 3);
        add(1, UD, 3, 0, 0, 7, c3(2, 3, 2), 3, 0, 2, 3);
        add(1, UD, 3, 0, 0, 7, c3(1, 2, 3), 1, 0, 1, 3);
        add(1, UD, 3, 0, 0, 7, c3(0, 1, 2), 0, 4, 0, 3);
        // saturating preload 9 -> 3
        add(1, UD, 3, 1, c3(9, 0, 0), 7, c3(3, 0, 0), 7, 0, 0, 3);
        add(1, UD, 3, 0, 0, 7, c3(2, 1, 1), 3, 0, 0, 3);
        // shadow period: 7 running, request 3 at count 2
        add(0, UP, 7, 0, 0, 7, c3(2, 1, 1), 3, 0, 0, 7);
        add(1, UP, 7, 1, 0, 7, a3(0), 7, 0, 0, 7);
        add(1, UP, 7, 0, 0, 7, a3(1), 7, 0, 0, 7);
        add(1, UP, 7, 0, 0, 7, a3(2), 7, 0, 0, 7);
        for (int k = 3; k <= 6; k++) add(1, UP, 3, 0, 0, 7, a3(8'(k)), 7, 0, 0, 7);
        add(1, UP, 3, 0, 0, 7, a3(7), 7, 0, 7, 7);
        add(1, UP, 3, 0, 0, 7, a3(0), 7, 7, 0, 3);
        add(1, UP, 3, 0, 0, 7, a3(1), 7, 0, 0, 3);
        add(1, UP, 3, 0, 0, 7, a3(2), 7, 0, 0, 3);
        add(1, UP, 3, 0, 0, 7, a3(3), 7, 0, 7, 3);
        add(1, UP, 3, 0, 0, 7, a3(0), 7, 7, 0, 3);
        // grow to 9, run to 5, then hold / disable
        add(1, UP, 9, 0, 0, 7, a3(1), 7, 0, 0, 3);
        add(1, UP, 9, 0, 0, 7, a3(2), 7, 0, 0, 3);
        add(1, UP, 9, 0, 0, 7, a3(3), 7, 0, 7, 3);
        add(1, UP, 9, 0, 0, 7, a3(0), 7, 7, 0, 9);
        for (int k = 1; k <= 5; k++) add(1, UP, 9, 0, 0, 7, a3(8'(k)), 7, 0, 0, 9);
        add(1, HD, 6, 0, 0, 7, a3(5), 7, 0, 0, 6);
        add(1, HD, 9, 0, 0, 7, a3(5), 7, 0, 0, 9);
        add(1, UP, 9, 0, 0, 7, a3(6), 7, 0, 0, 9);
        add(0, UP, 12, 0, 0, 7, a3(6), 7, 0, 0, 12);
        // down mode and a count above max_act
        for (int k = 5; k >= 1; k--) add(1, DN, 12, 0, 0, 7, a3(8'(k)), 7, 0, 0, 12);
        add(1, DN, 12, 0, 0, 7, a3(0), 7, 7, 0, 12);
        add(1, DN, 2, 0, 0, 7, a3(12), 7, 0, 7, 2);
        add(1, DN, 2, 0, 0, 7, a3(11), 7, 0, 0, 2);
        // zero period
        add(0, DN, 0, 0, 0, 7, a3(11), 7, 0, 0, 0);
        add(1, DN, 0, 0, 0, 7, a3(0), 7, 7, 0, 0);
        add(1, UD, 0, 0, 0, 7, a3(0), 7, 7, 0, 0);

        reset_n = 1'b0;
        drive(0, UP, 0, 0, 0, 0);
        #12;
        chk_all(-1, a3(0), 7, 0, 0, 8'hff);
        reset_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].en, vecs[i].mode, vecs[i].maxc, vecs[i].sl, vecs[i].ph, vecs[i].pdir);
            tick();
            chk_all(i, vecs[i].ecnt, vecs[i].edir, vecs[i].ezp, vecs[i].etp, vecs[i].emax);
        end

        // async reset mid-period, no clock edge involved
        drive(0, UP, 7, 0, 0, 7);
        tick();
        drive(1, UP, 7, 0, 0, 7);
        for (int k = 0; k < 6; k++) tick();
        chk_all(100, a3(6), 7, 0, 0, 7);
        #3;
        reset_n = 1'b0;
        #1;
        chk_all(101, a3(0), 7, 0, 0, 8'hff);
        reset_n = 1'b1;
        tick();
        chk_all(102, a3(1), 7, 0, 0, 8'hff);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/carrier_counter.md
Name: carrier_counter

Overview:
Multi-channel, phase-shiftable carrier counter for PWM/gate-timing generation. It generalises the plain wrap-around counter with several features:
- NUM_CH channels sharing one period;
- up, down and up-down (triangle) modes;
- a shadowed period register, updated only at period boundaries;
- per-channel phase preload;
- registered zero and top event pulses.

Downstream comparators and gate sequencers consume the count and pulse outputs.

Parameters:
WIDTH, 8, bit width of each channel count and of max_count
NUM_CH, 3, number of carrier channels (>=1)

Ports:
clk  input  1  system clock, all logic on rising edge
reset_n  input  1  asynchronous active-low reset
enable  input  1  advance all channels by one step per cycle when high
mode  input  2  00 up, 01 down, 10 up-down, 11 hold; applied immediately
max_count  input  WIDTH  requested period top value, shadowed into max_act
sync_load  input  1  load phase/phase_dir into all channels; priority over enable
phase  input  NUM_CH*WIDTH  per-channel preload value, channel i at bits [i*WIDTH +: WIDTH]
phase_dir  input  NUM_CH  per-channel preload direction, 1 = up (up-down mode only)
count  output  NUM_CH*WIDTH  per-channel count, same packing as phase
dir  output  NUM_CH  per-channel current direction, 1 = up
zero_pulse  output  NUM_CH  one-cycle pulse, channel just stepped to 0
top_pulse  output  NUM_CH  one-cycle pulse, channel just stepped to max_act
max_act  output  WIDTH  period value currently in force

Behaviour:
- Reset (reset_n low, asynchronous):
  - count = 0, dir = all 1, zero_pulse = 0, top_pulse = 0, max_act = all ones.
  - Deassertion is taken synchronously by the surrounding design.
  - Reset mid-period abandons all state; no pulse is emitted on reset.
- max_act update: max_act <= max_count on any cycle where any of the following holds:
  - enable = 0;
  - mode = 11;
  - channel 0 hits a period boundary this cycle.
- Channel 0 period boundary:
  - up mode: wrap max_act -> 0;
  - down mode: wrap 0 -> max_act;
  - up-down mode: turnaround at 0.
- The new max_act takes effect from the next cycle.
- Priority: sync_load > enable/mode step > hold.
- sync_load = 1:
  - count[i] <= min(phase[i], max_act) (saturate);
  - dir[i] <= phase_dir[i];
  - all pulses <= 0;
  - max_act is not updated this cycle.
- Step rules, per channel, when enable = 1 and sync_load = 0:
  - up: if count >= max_act then count <= 0 and top_pulse = 0, zero_pulse = 1; else count+1, with top_pulse = 1 iff count+1 == max_act.
  - down: if count == 0 then count <= max_act and top_pulse = 1; else count-1, with zero_pulse = 1 iff count-1 == 0. A count above max_act decrements normally.
  - up-down, dir = 1: if count >= max_act then count <= max_act-1, dir <= 0. Otherwise count+1, with top_pulse = 1 iff the result == max_act.
  - up-down, dir = 0: if count == 0 then count <= 1, dir <= 1. Otherwise count-1, with zero_pulse = 1 iff the result == 0.
  - Up-down period is 2*max_act cycles; each extremum value is held for exactly one cycle.
  - dir changes only in up-down mode. It is retained across mode changes, and up-down resumes with the stored dir.
  - hold (11), or enable = 0: count and dir hold; pulses return to 0 the next cycle.
- Pulses:
  - Registered, coincident with the count value they describe.
  - Never high for two consecutive cycles unless max_act <= 1.
- max_act == 0: every enabled step leaves count = 0 and asserts zero_pulse, in any counting mode.
- Arithmetic is modulo 2^WIDTH internally, but no path produces overflow: compares use >=, and the up-down top path subtracts only when max_act >= 1.
- All channels are independent except that they share mode, enable, max_act and the channel-0 boundary.

Test Plan:
1. Reset-then-count, up mode, WIDTH=8, max_count=4, enable=1 -> ch0 count 0,1,2,3,4,0; top_pulse on the cycle count=4; zero_pulse on the cycle count returns to 0; period 5 cycles.
2. Up-down mode, max_count=3 -> count 0,1,2,3,2,1,0,1; dir flips after 3 and after 0; top_pulse at 3, zero_pulse at 0; period 6 cycles.
3. Phase shift: sync_load with phase = {2,1,0} and phase_dir = all 1, then up-down with max 3 -> ch1 leads ch0 by 1 step and ch2 by 2 steps. With phase[2]=9 and max_act=3 -> ch2 loads 3.
4. Shadow period: up mode, max 7 running, change max_count to 3 at ch0 count=2 -> ch0 continues to 7, wraps to 0, then wraps at 3. max_act changes only on the cycle after the wrap.
5. Hold and disable: mode=11 mid-count at 5 -> count frozen and pulses 0; max_act follows max_count immediately. enable=0 gives the same.
6. Asynchronous reset at ch0 count=6 mid-period, no clock edge -> count=0, dir=1 and max_act=all ones immediately; the first enabled cycle after release gives count=1.
